// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the decoder/write-back stage and the
// multi-cycle RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [4:0]      rd_in;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [4:0]      rd_out;
   logic [XLEN-1:0] result;
   logic            stall;

   modport master (
      output in_valid, funct3, rd_in, op_a, op_b, kill, out_ready,
      input  in_ready, out_valid, rd_out, result, stall
   );

   modport slave (
      input  in_valid, funct3, rd_in, op_a, op_b, kill, out_ready,
      output in_ready, out_valid, rd_out, result, stall
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide on a
// shared 64-bit accumulator, with sign fix-up and divide special cases.
module muldiv_seq #(
   parameter int XLEN         = 32,
   parameter int CNT_W        = 5,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input logic         clk,
   input logic         rst,
   muldiv_seq_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_funct3;
   logic [4:0]        r_rd;
   logic              r_sa;
   logic              r_sb;
   logic              r_divZero;
   logic [XLEN-1:0]   r_magA;
   logic [XLEN-1:0]   r_magB;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rdOut;

   logic              w_idle;
   logic              w_accept;
   logic              w_isDiv;
   logic              w_signedA;
   logic              w_signedB;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_magA;
   logic [XLEN-1:0]   w_magB;
   logic              w_bZero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_specialResult;
   logic [XLEN:0]     w_mulSum;
   logic [XLEN:0]     w_remShift;
   logic              w_fits;
   logic [XLEN-1:0]   w_diff;
   logic [2*XLEN-1:0] w_calcNext;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_fixResult;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = bus.in_valid & w_idle & ~bus.kill;
   assign w_isDiv  = bus.funct3[2];

   // Operand signedness: MUL/MULH/DIV/REM both signed, MULHSU only rs1
   always_comb begin
      w_signedA = 1'b0;
      w_signedB = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            w_signedA = 1'b1;
            w_signedB = 1'b1;
         end
         3'b010:  w_signedA = 1'b1;
         default: ;
      endcase
   end

   assign w_sa   = w_signedA & bus.op_a[XLEN-1];
   assign w_sb   = w_signedB & bus.op_b[XLEN-1];
   assign w_magA = w_sa ? (~bus.op_a + 1'b1) : bus.op_a;
   assign w_magB = w_sb ? (~bus.op_b + 1'b1) : bus.op_b;

   assign w_bZero   = (bus.op_b == '0);
   assign w_ovf     = ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                      & (bus.op_b == '1);
   assign w_special = w_isDiv & (w_bZero | w_ovf);

   always_comb begin
      w_specialResult = '0;
      if (w_bZero) begin
         w_specialResult = bus.funct3[1] ? bus.op_a : '1;
      end else if (!bus.funct3[1]) begin
         w_specialResult = {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   // One shift-add multiply step: add multiplicand into the high half, shift right
   assign w_mulSum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + (r_acc[0] ? {1'b0, r_magA} : {(XLEN+1){1'b0}});

   assign w_remShift = r_acc[2*XLEN-1:XLEN-1];
   assign w_fits     = (w_remShift >= {1'b0, r_magB});
   assign w_diff     = w_remShift[XLEN-1:0] - r_magB;

   always_comb begin
      if (r_funct3[2]) begin
         if (w_fits) begin
            w_calcNext = {w_diff, r_acc[XLEN-2:0], 1'b1};
         end else begin
            w_calcNext = {r_acc[2*XLEN-2:0], 1'b0};
         end
      end else begin
         w_calcNext = {w_mulSum, r_acc[XLEN-1:1]};
      end
   end

   // Divide-by-zero keeps the all-ones quotient regardless of dividend sign
   assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
   assign w_quot = r_divZero ? '1
                 : ((r_sa ^ r_sb) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0]);
   assign w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      case (r_funct3)
         3'b000:         w_fixResult = w_prod[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:         w_fixResult = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101: w_fixResult = w_quot;
         default:        w_fixResult = w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_rd      <= '0;
         r_sa      <= 1'b0;
         r_sb      <= 1'b0;
         r_divZero <= 1'b0;
         r_magA    <= '0;
         r_magB    <= '0;
         r_acc     <= '0;
         r_result  <= '0;
         r_rdOut   <= '0;
      end else if (bus.kill && !w_idle) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_funct3  <= bus.funct3;
                  r_rd      <= bus.rd_in;
                  r_sa      <= w_sa;
                  r_sb      <= w_sb;
                  r_divZero <= w_isDiv & w_bZero;
                  r_magA    <= w_magA;
                  r_magB    <= w_magB;
                  r_cnt     <= '0;
                  if (FAST_SPECIAL && w_special) begin
                     r_result <= w_specialResult;
                     r_rdOut  <= bus.rd_in;
                     r_state  <= S_DONE;
                  end else begin
                     r_acc   <= w_isDiv ? {{XLEN{1'b0}}, w_magA} : {{XLEN{1'b0}}, w_magB};
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_calcNext;
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_FIX: begin
               r_result <= w_fixResult;
               r_rdOut  <= r_rd;
               r_state  <= S_DONE;
            end
            default: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = w_idle;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.rd_out    = r_rdOut;
   assign bus.stall     = ~w_idle | (bus.in_valid & w_idle);
endmodule
